// File: rtl/psx_controller_if.sv
// PSX serial link between console (master) and pad (slave): select, clock, command, data, acknowledge.
interface psx_controller_if;
    logic att;
    logic psx_clk;
    logic cmd;
    logic data;
    logic ack;

    modport master (output att, output psx_clk, output cmd, input data, input ack);
    modport slave  (input att, input psx_clk, input cmd, output data, output ack);
endinterface

// File: rtl/psx_controller.sv
// PlayStation digital pad (ID 0x41) responder on the PSX serial link.
// Optional PSX_CTRL_CMD_CHECK_EN: reject polls whose byte 0/1 command is not 0x01/0x42.
module psx_controller #(
    parameter int ACK_DELAY = 20,
    parameter int ACK_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    psx_controller_if.slave link,
    input  logic [15:0]     button_state,
    output logic            busy,
    output logic            poll_done,
    output logic [7:0]      last_cmd
);

    localparam int CNT_W = $clog2(ACK_DELAY + ACK_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(ACK_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_ACK_WAIT = 3'd2,
        S_ACK_LOW  = 3'd3,
        S_IGNORE   = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [2:0]       att_sync_r, psx_clk_sync_r;
    logic [1:0]       cmd_sync_r;
    logic [2:0]       bit_cnt_r, bit_cnt_nxt_s;
    logic [2:0]       byte_idx_r, byte_idx_nxt_s, byte_idx_inc_s;
    logic [7:0]       rx_r, rx_nxt_s, tx_r, tx_nxt_s;
    logic [15:0]      snap_r, snap_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             data_r, data_nxt_s, ack_r, ack_nxt_s;
    logic             busy_r, busy_nxt_s, poll_done_r, poll_done_nxt_s;
    logic [7:0]       last_cmd_r, last_cmd_nxt_s;
    logic             att_rise_s, att_fall_s, sclk_rise_s, sclk_fall_s;
    logic             byte_done_s, last_byte_s, cmd_bad_s;
    logic [7:0]       rx_byte_s, next_tx_s;

    function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [15:0] snap);
        case (idx)
            3'd0:    resp_byte = 8'hFF;
            3'd1:    resp_byte = 8'h41;
            3'd2:    resp_byte = 8'h5A;
            3'd3:    resp_byte = snap[7:0];
            3'd4:    resp_byte = snap[15:8];
            default: resp_byte = 8'hFF;
        endcase
    endfunction

    // Two-flop synchronizers plus one delayed flop for edge detection; idle levels are high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_sync_r     <= 3'b111;
            psx_clk_sync_r <= 3'b111;
            cmd_sync_r     <= 2'b11;
        end else begin
            att_sync_r     <= {att_sync_r[1:0], link.att};
            psx_clk_sync_r <= {psx_clk_sync_r[1:0], link.psx_clk};
            cmd_sync_r     <= {cmd_sync_r[0], link.cmd};
        end
    end

    assign att_rise_s     = att_sync_r[1] & ~att_sync_r[2];
    assign att_fall_s     = ~att_sync_r[1] & att_sync_r[2];
    assign sclk_rise_s    = psx_clk_sync_r[1] & ~psx_clk_sync_r[2];
    assign sclk_fall_s    = ~psx_clk_sync_r[1] & psx_clk_sync_r[2];
    assign rx_byte_s      = {cmd_sync_r[1], rx_r[7:1]};
    assign byte_done_s    = (state_r == S_SHIFT) && sclk_rise_s && (bit_cnt_r == 3'd7);
    assign last_byte_s    = (byte_idx_r >= 3'd4);
    assign byte_idx_inc_s = byte_idx_r + 3'd1;
    assign next_tx_s      = resp_byte(byte_idx_inc_s, snap_r);

`ifdef PSX_CTRL_CMD_CHECK_EN
    assign cmd_bad_s = ((byte_idx_r == 3'd0) && (rx_byte_s != 8'h01)) ||
                       ((byte_idx_r == 3'd1) && (rx_byte_s != 8'h42));
`else
    assign cmd_bad_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a deselect from the console overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (att_rise_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:     state_nxt_s = att_fall_s ? S_SHIFT : S_IDLE;
                S_SHIFT: begin
                    if (byte_done_s) begin
                        state_nxt_s = (last_byte_s || cmd_bad_s) ? S_IGNORE : S_ACK_WAIT;
                    end else begin
                        state_nxt_s = S_SHIFT;
                    end
                end
                S_ACK_WAIT: state_nxt_s = (cnt_r == DELAY_LAST) ? S_ACK_LOW : S_ACK_WAIT;
                S_ACK_LOW:  state_nxt_s = (cnt_r == WIDTH_LAST) ? S_SHIFT : S_ACK_LOW;
                S_IGNORE:   state_nxt_s = att_sync_r[1] ? S_IDLE : S_IGNORE;
                default:    state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values; the ack counter starts at 1 to include the detection cycle.
    always_comb begin
        data_nxt_s      = data_r;
        poll_done_nxt_s = 1'b0;
        bit_cnt_nxt_s   = bit_cnt_r;
        byte_idx_nxt_s  = byte_idx_r;
        rx_nxt_s        = rx_r;
        tx_nxt_s        = tx_r;
        snap_nxt_s      = snap_r;
        cnt_nxt_s       = cnt_r;
        last_cmd_nxt_s  = last_cmd_r;
        ack_nxt_s       = (state_nxt_s != S_ACK_LOW);
        busy_nxt_s      = (state_nxt_s != S_IDLE);
        if (att_rise_s) begin
            data_nxt_s = 1'b1;
            cnt_nxt_s  = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (att_fall_s) begin
                        snap_nxt_s     = button_state;
                        byte_idx_nxt_s = 3'd0;
                        bit_cnt_nxt_s  = 3'd0;
                        tx_nxt_s       = resp_byte(3'd0, button_state);
                        data_nxt_s     = tx_nxt_s[0];
                    end else begin
                        data_nxt_s = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (sclk_rise_s) begin
                        rx_nxt_s      = rx_byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_idx_nxt_s = byte_idx_inc_s;
                            tx_nxt_s       = next_tx_s;
                            cnt_nxt_s      = CNT_ONE;
                            last_cmd_nxt_s = (byte_idx_r == 3'd1) ? rx_byte_s : last_cmd_r;
                            if (last_byte_s) begin
                                poll_done_nxt_s = 1'b1;
                                data_nxt_s      = 1'b1;
                            end else if (cmd_bad_s) begin
                                data_nxt_s = 1'b1;
                            end else begin
                                data_nxt_s = next_tx_s[0];
                            end
                        end else begin
                            data_nxt_s = data_r;
                        end
                    end else if (sclk_fall_s) begin
                        data_nxt_s = tx_r[bit_cnt_r];
                    end else begin
                        data_nxt_s = data_r;
                    end
                end
                S_ACK_WAIT: cnt_nxt_s = (cnt_r == DELAY_LAST) ? '0 : cnt_r + CNT_ONE;
                S_ACK_LOW:  cnt_nxt_s = (cnt_r == WIDTH_LAST) ? '0 : cnt_r + CNT_ONE;
                S_IGNORE:   data_nxt_s = 1'b1;
                default:    data_nxt_s = 1'b1;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= 3'd0;
            byte_idx_r  <= 3'd0;
            rx_r        <= 8'h00;
            tx_r        <= 8'hFF;
            snap_r      <= 16'hFFFF;
            cnt_r       <= '0;
            data_r      <= 1'b1;
            ack_r       <= 1'b1;
            busy_r      <= 1'b0;
            poll_done_r <= 1'b0;
            last_cmd_r  <= 8'h00;
        end else begin
            bit_cnt_r   <= bit_cnt_nxt_s;
            byte_idx_r  <= byte_idx_nxt_s;
            rx_r        <= rx_nxt_s;
            tx_r        <= tx_nxt_s;
            snap_r      <= snap_nxt_s;
            cnt_r       <= cnt_nxt_s;
            data_r      <= data_nxt_s;
            ack_r       <= ack_nxt_s;
            busy_r      <= busy_nxt_s;
            poll_done_r <= poll_done_nxt_s;
            last_cmd_r  <= last_cmd_nxt_s;
        end
    end

    assign link.data = data_r;
    assign link.ack  = ack_r;
    assign busy      = busy_r;
    assign poll_done = poll_done_r;
    assign last_cmd  = last_cmd_r;

endmodule

// File: tb/tb_psx_controller.sv
// Self-checking bench for psx_controller: a console-side driver, a per-poll reference model and corner sequences.
module tb_psx_controller;
    localparam int ACK_DELAY = 20;
    localparam int ACK_WIDTH = 6;
    localparam int WIN       = ACK_DELAY + ACK_WIDTH + 10;
    localparam int GAP       = 200;
`ifdef PSX_CTRL_CMD_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct {
        logic [15:0] btn0;
        logic [15:0] btn1;
        logic [7:0]  c2;
        logic [7:0]  c3;
        logic [7:0]  c4;
        logic [7:0]  exp_b3;
        logic [7:0]  exp_b4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] button_state = 16'hFFFF;
    logic        busy, poll_done;
    logic [7:0]  last_cmd;

    int   n_tests = 0;
    int   n_fail = 0;
    int   ack_pulses = 0;
    int   pd_pulses = 0;
    logic ack_q = 1'b1;

    logic [7:0] cmd_a [5];
    logic [7:0] resp_a [5];
    int         lat_a [5];
    int         len_a [5];
    int         pd_a [5];
    logic       d_pre_a [5];
    logic       d_post_a [5];
    logic [7:0] exp_data [5];
    logic       exp_ack [5];
    logic       exp_pd;
    logic [7:0] exp_last = 8'h00;

    psx_controller_if link ();

    psx_controller #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .link(link), .button_state(button_state),
        .busy(busy), .poll_done(poll_done), .last_cmd(last_cmd)
    );

    always #5 clk = ~clk;

    // Counts ack falling edges and poll_done cycles over the whole run.
    always @(posedge clk) begin
        ack_q <= link.ack;
        if (rst_n && ack_q && !link.ack) ack_pulses <= ack_pulses + 1;
        if (rst_n && poll_done) pd_pulses <= pd_pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of one poll: pad reply bytes, which bytes get acked, poll completion.
    task automatic model_poll(input logic [15:0] btn);
        logic [7:0] pad [5];
        bit alive;
        bit bad;
        pad[0] = 8'hFF; pad[1] = 8'h41; pad[2] = 8'h5A; pad[3] = btn[7:0]; pad[4] = btn[15:8];
        alive = 1'b1;
        for (int b = 0; b < 5; b++) begin
            exp_data[b] = alive ? pad[b] : 8'hFF;
            exp_ack[b]  = 1'b0;
            if (alive) begin
                if (b == 1) exp_last = cmd_a[1];
                bad = CHECK && ((b == 0 && cmd_a[0] != 8'h01) || (b == 1 && cmd_a[1] != 8'h42));
                exp_ack[b] = (b < 4) && !bad;
                if (bad) alive = 1'b0;
            end
        end
        exp_pd = alive;
    endtask

    // Console side: change cmd on psx_clk falling, sample data just before rising.
    task automatic shift_bits(input logic [7:0] c, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            link.psx_clk = 1'b0;
            link.cmd = c[i];
            repeat (6) @(negedge clk);
            r[i] = link.data;
            link.psx_clk = 1'b1;
            if (i < n - 1) repeat (6) @(negedge clk);
        end
    endtask

    task automatic xfer_byte(input int b);
        logic [7:0] r;
        shift_bits(cmd_a[b], 8, r);
        resp_a[b] = r;
        lat_a[b] = -1; len_a[b] = 0; pd_a[b] = -1;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (k == 2) d_pre_a[b] = link.data;
            if (k == 3) d_post_a[b] = link.data;
            if (poll_done && pd_a[b] < 0) pd_a[b] = k;
            if (!link.ack) begin
                if (lat_a[b] < 0) lat_a[b] = k;
                len_a[b]++;
            end
        end
    endtask

    task automatic run_poll(input string tag, input logic [15:0] btn0, input logic [15:0] btn1);
        int a0, q0, n_ack;
        logic exp_post;
        model_poll(btn0);
        a0 = ack_pulses; q0 = pd_pulses;
        button_state = btn0;
        link.att = 1'b0;
        repeat (8) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        button_state = btn1;
        for (int b = 0; b < 5; b++) xfer_byte(b);
        link.att = 1'b1;
        repeat (GAP) @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_last_cmd"}, 32'(last_cmd), 32'(exp_last));
        n_ack = 0;
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("%s_b%0d_data", tag, b), 32'(resp_a[b]), 32'(exp_data[b]));
            chk($sformatf("%s_b%0d_acked", tag, b), 32'(lat_a[b] >= 0), 32'(exp_ack[b]));
            if (exp_ack[b]) begin
                chk($sformatf("%s_b%0d_ack_lat", tag, b), 32'(lat_a[b]), 32'(ACK_DELAY + 2));
                chk($sformatf("%s_b%0d_ack_len", tag, b), 32'(len_a[b]), 32'(ACK_WIDTH));
                n_ack++;
            end
            chk($sformatf("%s_b%0d_poll_done", tag, b), 32'(pd_a[b]), (b == 4 && exp_pd) ? 32'd3 : 32'hFFFF_FFFF);
            chk($sformatf("%s_b%0d_bit7_hold", tag, b), 32'(d_pre_a[b]), 32'(exp_data[b][7]));
            if (b < 4) exp_post = exp_data[b+1][0];
            else exp_post = 1'b1;
            chk($sformatf("%s_b%0d_next_bit0", tag, b), 32'(d_post_a[b]), 32'(exp_post));
        end
        chk({tag, "_ack_count"}, 32'(ack_pulses - a0), 32'(n_ack));
        chk({tag, "_pd_count"}, 32'(pd_pulses - q0), 32'(exp_pd));
    endtask

    initial begin
        vec_t vecs [4];
        logic [7:0] r;
        int a0, q0;
        bit found;

        link.att = 1'b1; link.psx_clk = 1'b1; link.cmd = 1'b1;
        vecs[0] = '{16'hFFFE, 16'hFFFE, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF};
        vecs[1] = '{16'h0F0F, 16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F};
        vecs[2] = '{16'hA55A, 16'h0000, 8'hFF, 8'h00, 8'hAA, 8'h5A, 8'hA5};
        vecs[3] = '{16'h1234, 16'h1234, 8'h5A, 8'hC3, 8'h81, 8'h34, 8'h12};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_data", 32'(link.data), 32'd1);
        chk("reset_ack", 32'(link.ack), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_poll_done", 32'(poll_done), 32'd0);
        chk("reset_last_cmd", 32'(last_cmd), 32'd0);

        for (int v = 0; v < 4; v++) begin
            cmd_a = '{8'h01, 8'h42, vecs[v].c2, vecs[v].c3, vecs[v].c4};
            run_poll($sformatf("vec%0d", v), vecs[v].btn0, vecs[v].btn1);
            chk($sformatf("vec%0d_byte3", v), 32'(resp_a[3]), 32'(vecs[v].exp_b3));
            chk($sformatf("vec%0d_byte4", v), 32'(resp_a[4]), 32'(vecs[v].exp_b4));
        end

        // Abort: deselect in the middle of byte 2.
        cmd_a = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        q0 = pd_pulses;
        button_state = 16'h00FF;
        link.att = 1'b0;
        repeat (8) @(negedge clk);
        xfer_byte(0);
        xfer_byte(1);
        shift_bits(8'h00, 4, r);
        link.att = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_data", 32'(link.data), 32'd1);
        chk("abort_ack", 32'(link.ack), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (GAP) @(negedge clk);
        chk("abort_no_poll_done", 32'(pd_pulses - q0), 32'd0);
        exp_last = 8'h42;
        chk("abort_last_cmd", 32'(last_cmd), 32'h42);
        run_poll("after_abort", 16'hBEEF, 16'hBEEF);

        cmd_a = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00};
        run_poll("bad_cmd0", 16'h7E7E, 16'h7E7E);
        cmd_a = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00};
        run_poll("bad_cmd1", 16'h3C3C, 16'h3C3C);

        a0 = ack_pulses; q0 = pd_pulses;
        for (int p = 0; p < 6; p++) begin
            cmd_a = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
            run_poll($sformatf("b2b%0d", p), 16'($urandom), 16'($urandom));
        end
        chk("b2b_total_acks", 32'(ack_pulses - a0), 32'd24);
        chk("b2b_total_polls", 32'(pd_pulses - q0), 32'd6);

        for (int p = 0; p < 10; p++) begin
            cmd_a[0] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h01;
            cmd_a[1] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h42;
            cmd_a[2] = 8'($urandom);
            cmd_a[3] = 8'($urandom);
            cmd_a[4] = 8'($urandom);
            run_poll($sformatf("rnd%0d", p), 16'($urandom), 16'($urandom));
        end

        // Reset while ack is low: outputs must return high without a clock edge.
        cmd_a = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        button_state = 16'h0000;
        link.att = 1'b0;
        repeat (8) @(negedge clk);
        shift_bits(8'h01, 8, r);
        found = 1'b0;
        for (int k = 0; k < WIN && !found; k++) begin
            @(negedge clk);
            if (!link.ack) found = 1'b1;
        end
        chk("rst_mid_ack_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ack", 32'(link.ack), 32'd1);
        chk("rst_async_data", 32'(link.data), 32'd1);
        link.att = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_cmd", 32'(last_cmd), 32'd0);
        chk("rst_poll_done", 32'(poll_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
